// File: rtl/nibbler_pkg.sv
// Shared definitions for the Nibbler fetch/sequencing unit: opcode values,
// sequencer state encoding and the conditional-branch decision helper.
package nibbler_pkg;

    // Control-flow opcodes resolved by the sequencer itself
    localparam logic [3:0] OP_JC   = 4'h0;
    localparam logic [3:0] OP_JNC  = 4'h1;
    localparam logic [3:0] OP_JZ   = 4'h2;
    localparam logic [3:0] OP_JNZ  = 4'h3;
    localparam logic [3:0] OP_J    = 4'h4;
    localparam logic [3:0] OP_CALL = 4'h5;
    localparam logic [3:0] OP_RET  = 4'h6;

    // FETCH reads the opcode word, OPER the address word, COMMIT executes
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        OPER   = 2'd1,
        COMMIT = 2'd2
    } seq_state_e;

    // Decides whether a jump-family opcode transfers control given the flags
    function automatic logic branch_taken(input logic [3:0] op,
                                          input logic       c,
                                          input logic       z);
        logic taken;
        taken = 1'b0;
        case (op)
            OP_JC:   taken = c;
            OP_JNC:  taken = !c;
            OP_JZ:   taken = z;
            OP_JNZ:  taken = !z;
            OP_J:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/nibbler_ret_stack.sv
// Hardware return-address stack for CALL/RET. Pushes while full and pops
// while empty are ignored here; the sequencer reports those as stack errors.
module nibbler_ret_stack #(
    parameter int STACK_DEPTH = 4,
    parameter int ADDR_W      = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] top
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic [SP_W-1:0]   sp_q;
    logic [SP_W-1:0]   sp_d;
    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [ADDR_W-1:0] mem_d [STACK_DEPTH];

    assign full  = (sp_q == SP_W'(STACK_DEPTH));
    assign empty = (sp_q == '0);

    // Select the most recently pushed entry without a variable array index
    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) begin
                top = mem_q[i];
            end
        end
    end

    // Compute the next stack pointer and contents for a push or a pop
    always_comb begin
        sp_d  = sp_q;
        mem_d = mem_q;
        if (push && !full) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (sp_q == SP_W'(i)) begin
                    mem_d[i] = push_data;
                end
            end
            sp_d = sp_q + 1'b1;
        end else if (pop && !empty) begin
            sp_d = sp_q - 1'b1;
        end
    end

    // Stack registers; reset empties the stack and clears stale entries
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sp_q  <= sp_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/nibbler_sequencer.sv
// Nibbler fetch/sequencing unit: fetches two-word instructions over a
// req/ack program-memory port, resolves jumps, CALL and RET, and strobes
// commit for one cycle so the datapath can execute the latched instruction.
module nibbler_sequencer
    import nibbler_pkg::*;
#(
    parameter int                   DATA_W      = 4,
    parameter int                   STACK_DEPTH = 4,
    parameter logic [2*DATA_W+3:0]  RESET_VEC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [2*DATA_W+3:0]   prog_addr,
    output logic                  prog_req,
    input  logic                  prog_ack,
    input  logic [DATA_W+3:0]     prog_data,
    input  logic                  flag_c,
    input  logic                  flag_z,
    input  logic                  hold,
    output logic                  phase,
    output logic [3:0]            instr,
    output logic [DATA_W-1:0]     operand,
    output logic [2*DATA_W+3:0]   addr_con,
    output logic                  commit,
    output logic                  stack_err
);

    localparam int PROG_W = 4 + DATA_W;
    localparam int ADDR_W = DATA_W + PROG_W;

    seq_state_e        state_q;
    seq_state_e        state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [3:0]        instr_q;
    logic [3:0]        instr_d;
    logic [DATA_W-1:0] operand_q;
    logic [DATA_W-1:0] operand_d;
    logic [ADDR_W-1:0] addr_con_q;
    logic [ADDR_W-1:0] addr_con_d;
    logic              stack_err_q;
    logic              stack_err_d;
    logic              req_en_q;
    logic              req_en_d;

    logic              stk_push;
    logic              stk_pop;
    logic              stk_full;
    logic              stk_empty;
    logic [ADDR_W-1:0] stk_top;

    nibbler_ret_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .ADDR_W      (ADDR_W)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_q),
        .full      (stk_full),
        .empty     (stk_empty),
        .top       (stk_top)
    );

    assign prog_addr = pc_q;
    assign phase     = (state_q != FETCH);
    assign instr     = instr_q;
    assign operand   = operand_q;
    assign addr_con  = addr_con_q;
    assign stack_err = stack_err_q;

    // Next-state, handshake and control-flow resolution for the fetch FSM
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        operand_d   = operand_q;
        addr_con_d  = addr_con_q;
        stack_err_d = stack_err_q;
        req_en_d    = 1'b1;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        prog_req    = 1'b0;
        commit      = 1'b0;

        case (state_q)
            FETCH: begin
                prog_req = req_en_q;
                if (req_en_q && prog_ack) begin
                    instr_d   = prog_data[PROG_W-1:DATA_W];
                    operand_d = prog_data[DATA_W-1:0];
                    pc_d      = pc_q + 1'b1;
                    state_d   = OPER;
                end
            end
            OPER: begin
                prog_req = 1'b1;
                if (prog_ack) begin
                    addr_con_d = {operand_q, prog_data};
                    pc_d       = pc_q + 1'b1;
                    state_d    = COMMIT;
                end
            end
            COMMIT: begin
                commit = !hold;
                if (!hold) begin
                    state_d = FETCH;
                    case (instr_q)
                        OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_J: begin
                            if (branch_taken(instr_q, flag_c, flag_z)) begin
                                pc_d = addr_con_q;
                            end
                        end
                        OP_CALL: begin
                            if (stk_full) begin
                                stack_err_d = 1'b1;
                            end else begin
                                stk_push = 1'b1;
                            end
                            pc_d = addr_con_q;
                        end
                        OP_RET: begin
                            if (stk_empty) begin
                                stack_err_d = 1'b1;
                            end else begin
                                stk_pop = 1'b1;
                                pc_d    = stk_top;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Sequencer registers; reset aborts any handshake in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_VEC;
            instr_q     <= '0;
            operand_q   <= '0;
            addr_con_q  <= '0;
            stack_err_q <= 1'b0;
            req_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            operand_q   <= operand_d;
            addr_con_q  <= addr_con_d;
            stack_err_q <= stack_err_d;
            req_en_q    <= req_en_d;
        end
    end

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Self-checking bench for nibbler_sequencer: directed vector table, multi-cycle
// corner sequences (waits, hold, call/ret chain, wrap, reset in OPER) and a
// randomized run against an instruction-level reference model.
module tb_nibbler_sequencer;

    localparam int DEPTH = 3;

    logic        clk;
    logic        reset;
    logic [11:0] prog_addr;
    logic        prog_req;
    logic        prog_ack;
    logic [7:0]  prog_data;
    logic        flag_c;
    logic        flag_z;
    logic        hold;
    logic        phase;
    logic [3:0]  instr;
    logic [3:0]  operand;
    logic [11:0] addr_con;
    logic        commit;
    logic        stack_err;

    logic [7:0]  pmem [0:4095];
    int          check_count;
    int          pass_count;

    typedef struct {
        logic [7:0]  w0;
        logic [7:0]  w1;
        logic        fc;
        logic        fz;
        logic [3:0]  e_instr;
        logic [3:0]  e_operand;
        logic [11:0] e_addr_con;
        logic [11:0] e_next;
    } vec_t;

    vec_t        vecs [7];
    logic [11:0] chain_next [13];
    logic        chain_err [13];

    nibbler_sequencer #(
        .DATA_W      (4),
        .STACK_DEPTH (DEPTH),
        .RESET_VEC   (12'h000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .prog_addr (prog_addr),
        .prog_req  (prog_req),
        .prog_ack  (prog_ack),
        .prog_data (prog_data),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .hold      (hold),
        .phase     (phase),
        .instr     (instr),
        .operand   (operand),
        .addr_con  (addr_con),
        .commit    (commit),
        .stack_err (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a wait somewhere never resolves
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ack, input logic h, input logic fc, input logic fz);
        prog_ack  = ack;
        hold      = h;
        flag_c    = fc;
        flag_z    = fz;
        prog_data = pmem[prog_addr];
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fillMem(input logic [7:0] val);
        for (int i = 0; i < 4096; i++) pmem[i] = val;
    endtask

    task automatic put(input logic [11:0] a, input logic [7:0] w0, input logic [7:0] w1);
        pmem[a]         = w0;
        pmem[a + 12'd1] = w1;
    endtask

    task automatic resetDut();
        reset    = 1'b1;
        prog_ack = 1'b0;
        hold     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Run one instruction from FETCH; waits per word, hold cycles in COMMIT
    task automatic runOne(input logic [11:0] start_pc, input int waits, input int holds,
                          input logic fc, input logic fz,
                          output int commit_cycle, output logic [11:0] next_addr);
        int cyc;
        int waited;
        int word;
        int holds_left;
        bit done;
        logic [11:0] ea;
        cyc = 1; waited = 0; word = 0; holds_left = holds; done = 0;
        commit_cycle = -1;
        while (!done && cyc <= 60) begin
            if (word < 2) begin
                applyStimulus(prog_req && (waited >= waits), 1'b0, fc, fz);
                ea = start_pc + 12'(word);
                checkOutput("fetch_addr", prog_addr, ea);
                checkOutput("fetch_phase", phase, (word == 1));
                if (prog_req && prog_ack) begin
                    word++;
                    waited = 0;
                end else begin
                    waited++;
                end
            end else begin
                applyStimulus(1'b1, (holds_left > 0), fc, fz);
                checkOutput("commit_req_low", prog_req, 1'b0);
                checkOutput("commit_phase", phase, 1'b1);
                if (commit) begin
                    commit_cycle = cyc;
                    done = 1;
                end
                if (holds_left > 0) holds_left--;
            end
            nextCycle();
            cyc++;
        end
        if (!done) checkOutput("commit_timeout", 32'd0, 32'd1);
        applyStimulus(1'b0, 1'b0, fc, fz);
        next_addr = prog_addr;
    endtask

    initial begin
        int          ccyc;
        logic [11:0] nxt;
        logic [11:0] pc;
        logic [11:0] m_pc;
        logic [11:0] m_tgt;
        logic [11:0] m_ret;
        logic [11:0] m_stack [$];
        logic [7:0]  mw0;
        logic [7:0]  mw1;
        logic        m_err;
        int          word;
        int          waited;
        int          cur_wait;
        logic        fc, fz, h, a;

        check_count = 0;
        pass_count  = 0;
        reset = 1'b1; prog_ack = 1'b0; prog_data = '0;
        hold = 1'b0; flag_c = 1'b0; flag_z = 1'b0;

        vecs[0] = '{8'h70, 8'h12, 1'b0, 1'b0, 4'h7, 4'h0, 12'h012, 12'h002};
        vecs[1] = '{8'h03, 8'hA5, 1'b1, 1'b0, 4'h0, 4'h3, 12'h3A5, 12'h3A5};
        vecs[2] = '{8'h03, 8'hA5, 1'b0, 1'b1, 4'h0, 4'h3, 12'h3A5, 12'h002};
        vecs[3] = '{8'h3A, 8'h5C, 1'b1, 1'b0, 4'h3, 4'hA, 12'hA5C, 12'hA5C};
        vecs[4] = '{8'h2B, 8'h11, 1'b1, 1'b0, 4'h2, 4'hB, 12'hB11, 12'h002};
        vecs[5] = '{8'h1C, 8'h44, 1'b1, 1'b1, 4'h1, 4'hC, 12'hC44, 12'h002};
        vecs[6] = '{8'h4F, 8'h00, 1'b0, 1'b0, 4'h4, 4'hF, 12'hF00, 12'hF00};

        chain_next = '{12'h010, 12'h100, 12'h012, 12'h200, 12'h300, 12'h400,
                       12'h500, 12'h302, 12'h202, 12'h014, 12'h016, 12'hFFE, 12'h000};
        chain_err  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                       1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset state and the first request after release
        fillMem(8'hF0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_prog_req", prog_req, 1'b0);
        checkOutput("rst_phase", phase, 1'b0);
        checkOutput("rst_commit", commit, 1'b0);
        checkOutput("rst_stack_err", stack_err, 1'b0);
        checkOutput("rst_instr", instr, 4'h0);
        checkOutput("rst_operand", operand, 4'h0);
        checkOutput("rst_addr_con", addr_con, 12'h000);
        checkOutput("rst_prog_addr", prog_addr, 12'h000);
        reset = 1'b0;
        #1;
        checkOutput("req_before_edge", prog_req, 1'b0);
        @(negedge clk);
        checkOutput("req_after_edge", prog_req, 1'b1);

        // Single-instruction vectors with zero-wait memory
        for (int i = 0; i < 7; i++) begin
            fillMem(8'hF0);
            put(12'h000, vecs[i].w0, vecs[i].w1);
            resetDut();
            runOne(12'h000, 0, 0, vecs[i].fc, vecs[i].fz, ccyc, nxt);
            checkOutput($sformatf("vec%0d_commit_cycle", i), ccyc, 3);
            checkOutput($sformatf("vec%0d_instr", i), instr, vecs[i].e_instr);
            checkOutput($sformatf("vec%0d_operand", i), operand, vecs[i].e_operand);
            checkOutput($sformatf("vec%0d_addr_con", i), addr_con, vecs[i].e_addr_con);
            checkOutput($sformatf("vec%0d_next_addr", i), nxt, vecs[i].e_next);
        end

        // Two wait states per word
        fillMem(8'hF0);
        put(12'h000, 8'h70, 8'h12);
        resetDut();
        runOne(12'h000, 2, 0, 1'b0, 1'b0, ccyc, nxt);
        checkOutput("wait_commit_cycle", ccyc, 7);
        checkOutput("wait_addr_con", addr_con, 12'h012);
        checkOutput("wait_next_addr", nxt, 12'h002);

        // Three hold cycles in COMMIT before the single commit pulse
        runOne(12'h002, 0, 3, 1'b0, 1'b0, ccyc, nxt);
        checkOutput("hold_commit_cycle", ccyc, 6);
        checkOutput("hold_next_addr", nxt, 12'h004);

        // CALL/RET chain: nesting, overflow, LIFO unwind, underflow, wrap
        fillMem(8'hF0);
        put(12'h000, 8'h40, 8'h10);
        put(12'h010, 8'h51, 8'h00);
        put(12'h100, 8'h60, 8'h00);
        put(12'h012, 8'h52, 8'h00);
        put(12'h200, 8'h53, 8'h00);
        put(12'h300, 8'h54, 8'h00);
        put(12'h400, 8'h55, 8'h00);
        put(12'h500, 8'h60, 8'h00);
        put(12'h302, 8'h60, 8'h00);
        put(12'h202, 8'h60, 8'h00);
        put(12'h014, 8'h60, 8'h00);
        put(12'h016, 8'h4F, 8'hFE);
        put(12'hFFE, 8'hF0, 8'h00);
        resetDut();
        pc = 12'h000;
        for (int i = 0; i < 13; i++) begin
            runOne(pc, 0, 0, 1'b0, 1'b0, ccyc, nxt);
            checkOutput($sformatf("chain%0d_next_addr", i), nxt, chain_next[i]);
            checkOutput($sformatf("chain%0d_stack_err", i), stack_err, chain_err[i]);
            pc = chain_next[i];
        end

        // Reset asserted while the second word is being requested
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("oper_phase", phase, 1'b1);
        checkOutput("oper_addr", prog_addr, 12'h001);
        reset = 1'b1;
        #1;
        checkOutput("midrst_req", prog_req, 1'b0);
        checkOutput("midrst_pc", prog_addr, 12'h000);
        checkOutput("midrst_phase", phase, 1'b0);
        checkOutput("midrst_instr", instr, 4'h0);
        checkOutput("midrst_stack_err", stack_err, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        runOne(12'h000, 0, 0, 1'b0, 1'b0, ccyc, nxt);
        checkOutput("postrst_commit_cycle", ccyc, 3);
        checkOutput("postrst_next_addr", nxt, 12'h010);

        // Randomized program against an instruction-level reference model
        for (int i = 0; i < 4096; i++) pmem[i] = 8'($urandom);
        resetDut();
        m_pc = 12'h000; m_err = 1'b0; m_stack.delete();
        word = 0; waited = 0; cur_wait = $urandom_range(0, 2);
        mw0 = '0; mw1 = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            fc = 1'($urandom_range(0, 1));
            fz = 1'($urandom_range(0, 1));
            h  = ($urandom_range(0, 2) == 0);
            if (word < 2) a = (waited >= cur_wait);
            else          a = 1'($urandom_range(0, 1));
            applyStimulus(a, h, fc, fz);
            checkOutput("rnd_stack_err", stack_err, m_err);
            if (word < 2) begin
                checkOutput("rnd_req", prog_req, 1'b1);
                checkOutput("rnd_addr", prog_addr, m_pc + 12'(word));
                checkOutput("rnd_phase", phase, (word == 1));
                checkOutput("rnd_commit_idle", commit, 1'b0);
                if (a) begin
                    if (word == 0) mw0 = pmem[m_pc];
                    else           mw1 = pmem[m_pc + 12'd1];
                    word++;
                    waited   = 0;
                    cur_wait = $urandom_range(0, 2);
                end else begin
                    waited++;
                end
            end else begin
                checkOutput("rnd_req_commit", prog_req, 1'b0);
                checkOutput("rnd_phase_commit", phase, 1'b1);
                checkOutput("rnd_commit", commit, !h);
                if (!h) begin
                    checkOutput("rnd_instr", instr, mw0[7:4]);
                    checkOutput("rnd_operand", operand, mw0[3:0]);
                    checkOutput("rnd_addr_con", addr_con, {mw0[3:0], mw1});
                    m_tgt = {mw0[3:0], mw1};
                    m_ret = m_pc + 12'd2;
                    case (mw0[7:4])
                        4'h0: m_pc = fc ? m_tgt : m_ret;
                        4'h1: m_pc = !fc ? m_tgt : m_ret;
                        4'h2: m_pc = fz ? m_tgt : m_ret;
                        4'h3: m_pc = !fz ? m_tgt : m_ret;
                        4'h4: m_pc = m_tgt;
                        4'h5: begin
                            if (m_stack.size() < DEPTH) m_stack.push_back(m_ret);
                            else                        m_err = 1'b1;
                            m_pc = m_tgt;
                        end
                        4'h6: begin
                            if (m_stack.size() > 0) begin
                                m_pc = m_stack.pop_back();
                            end else begin
                                m_err = 1'b1;
                                m_pc  = m_ret;
                            end
                        end
                        default: m_pc = m_ret;
                    endcase
                    word = 0;
                end
            end
            nextCycle();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/nibbler_sequencer.md
Name: nibbler_sequencer

Overview:
Parametrised fetch/sequencing unit, successor to the fixed two-phase Nibbler fetch/PC/phase logic. It fetches two-word instructions over a req/ack program-memory handshake that supports wait states. It resolves conditional jumps, and adds CALL/RET with a hardware return stack. It sits between program ROM and the microcode decoder, providing instr/operand/addr_con and a one-cycle commit strobe to the datapath.

Parameters:
DATA_W, 4, operand/datapath width; PROG_W = 4+DATA_W (program word), ADDR_W = DATA_W+PROG_W (derived localparams)
STACK_DEPTH, 4, return-stack entries (>=1)
RESET_VEC, 0, PC value after reset (ADDR_W bits)

Ports:
clk  in  1  clock
reset  in  1  reset; asynchronous, active-high
prog_addr  out  ADDR_W  program memory address (= pc)
prog_req  out  1  program read request
prog_ack  in  1  read data valid this cycle; may coincide with req (zero-wait)
prog_data  in  PROG_W  program word
flag_c  in  1  carry flag from flags register
flag_z  in  1  zero flag
hold  in  1  datapath stall; extends COMMIT
phase  out  1  0 in FETCH, 1 in OPER/COMMIT
instr  out  4  latched opcode
operand  out  DATA_W  latched operand
addr_con  out  ADDR_W  {operand, second word}, RAM/jump address
commit  out  1  one-cycle execute strobe for datapath load enables
stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (async): state=FETCH, pc=RESET_VEC, instr=0, operand=0, addr_con=0, sp=0, stack_err=0. commit=0. prog_req=0 while reset is high; prog_req is asserted from the first edge after release.
- FETCH: prog_req=1, prog_addr=pc. On ack: instr<=prog_data[PROG_W-1:DATA_W], operand<=prog_data[DATA_W-1:0], pc<=pc+1, go to OPER. Without ack: hold all state.
- OPER: prog_req=1. On ack: addr_con<={operand, prog_data}, pc<=pc+1, go to COMMIT.
- COMMIT: prog_req=0. commit = !hold. While hold=1, stay in COMMIT with no state change. On the cycle with hold=0, resolve the instruction and go to FETCH:
  - JC: taken if flag_c; JNC: taken if !flag_c; JZ: taken if flag_z; JNZ: taken if !flag_z; J: always taken. Taken -> pc<=addr_con. Not taken -> pc unchanged.
  - CALL: if sp<STACK_DEPTH, push pc (already the return address) and sp++; if full, set stack_err, do not push. Jump in both cases.
  - RET: if sp>0, sp-- and pc<=stack[sp-1]; if empty, set stack_err and pc is unchanged (acts as a no-op).
  - All other opcodes: pc unchanged. They belong to the datapath, which acts on commit.
- Flags are sampled only in the commit cycle.
- Latency: with zero-wait memory, each instruction takes 3 cycles. Each memory wait cycle adds 1. Each hold cycle adds 1.
- pc arithmetic is modulo 2^ADDR_W: all-ones+1 wraps to 0, and a fetch across the wrap is legal.
- instr/operand/addr_con stay stable from their load until the next overwrite. They are valid throughout COMMIT.
- prog_ack while prog_req=0 is ignored.
- stack_err clears only on reset.
- Reset mid-handshake aborts the transaction; no partial state survives.

Decomposition:
- nibbler_pkg holds the opcode constants (4-bit): OP_JC=4'h0, OP_JNC=4'h1, OP_JZ=4'h2, OP_JNZ=4'h3, OP_J=4'h4, OP_CALL=4'h5, OP_RET=4'h6. It also holds the state enum (FETCH, OPER, COMMIT).
- Sub-module nibbler_ret_stack: parameters STACK_DEPTH and ADDR_W, with push/pop/full/empty/top. It has its own async active-high reset, and simultaneous push+pop is never issued by the sequencer.

Test Plan:
- Zero-wait sequence: ack tied to req, words 0x70,0x12 at 0x000/0x001 (non-branch) -> instr=7, operand=0, addr_con=0x012, commit on cycle 3, next fetch addr 0x002.
- Wait states: ack delayed 2 cycles per word -> commit on cycle 7, prog_addr held constant while waiting, phase=0 then 1.
- Conditional: JC 0x3A5 with flag_c=1 -> next prog_addr 0x3A5. Same with flag_c=0 -> 0x002. JNZ with flag_z=0 -> taken.
- Call/ret: CALL 0x100 at 0x010, RET at 0x100 -> fetch 0x100, then 0x012. Three nested calls unwind in LIFO order.
- Stack bounds (STACK_DEPTH=2): third nested CALL -> jumps, stack_err=1. RET with sp=0 -> pc advances normally, stack_err stays 1.
- Hold, wrap and reset: hold=1 for 3 cycles in COMMIT -> commit low, then a single pulse. Instruction at 0xFFE -> next fetch 0x000. reset asserted during OPER -> prog_req=0 and pc=RESET_VEC immediately.
